bram_serial_seq: RTL and testbench
==================================

Name: bram_serial_seq

Overview:
- Serial-command sequencer for a single block-RAM port (RAMB36E1 port A style: en/we/addr/din/dout) in bitstream-fuzzing minitests.
- Accepts command frames shifted in one bit per clock on di and executes the latched frame on stb: write, read, or write-then-readback.
- Shifts read data out serially on do, so a BRAM can be exercised through a 3-pin interface.

Parameters:
- ADDR_W, 10, BRAM address width
- DATA_W, 8, data width (1..32)
- READ_LAT, 1, BRAM read latency in cycles (1 = DO_REG off, 2 = DO_REG on); legal values 1..2

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- di  in  1  serial command bit, shifted in every cycle, MSB of frame first
- stb  in  1  latch the current shift-register contents as a command
- do  out  1  serial read data, MSB first
- busy  out  1  command in progress
- overrun  out  1  sticky: stb arrived while busy
- bram_en  out  1  BRAM enable
- bram_we  out  1  BRAM write enable
- bram_addr  out  ADDR_W  BRAM address
- bram_wdata  out  DATA_W  BRAM write data
- bram_rdata  in  DATA_W  BRAM read data
- bram_wpar  out  1  write parity bit to DIP
- bram_rpar  in  1  read parity bit from DOP
- par_err  out  1  sticky parity mismatch

Behaviour:
- Frame: FRAME_W = 2+ADDR_W+DATA_W bits in the order {op[1:0], addr, data}.
- Shift register: shr <= {shr[FRAME_W-2:0], di} every cycle, including reset release and while busy.
- Op codes: 00 NOP, 01 WRITE, 10 READ, 11 WRITE-then-READ (same address).
- Reset state: all registers 0, state IDLE. Outputs do, busy, overrun, bram_en, bram_we, bram_addr, bram_wdata, bram_wpar and par_err are all 0.
- States: IDLE, ISSUE_W, ISSUE_R, WAIT, SHIFT.
- IDLE with stb=1: latch op/addr/data into cmd registers; bram_addr and bram_wdata come from these.
  - 01 -> ISSUE_W
  - 10 -> ISSUE_R
  - 11 -> ISSUE_W
  - 00 -> stay IDLE
- ISSUE_W: one cycle, bram_en=1 and bram_we=1. Then op 01 -> IDLE, op 11 -> ISSUE_R.
- ISSUE_R: one cycle, bram_en=1 and bram_we=0; load wait counter with READ_LAT-1; go to WAIT.
- WAIT: counter decrements each cycle. In the cycle the counter is 0, capture bram_rdata into the output shift register and go to SHIFT.
- SHIFT: do = out_shr[DATA_W-1]; shift left with zero fill for DATA_W cycles, then go to IDLE.
- do is 0 outside SHIFT.
- bram_en and bram_we are registered outputs, high only in the stated states.
- busy = (state != IDLE).
- Latency, stb sampled at cycle t:
  - WRITE: en/we high during t+1; busy high for cycle t+1 only.
  - READ: en high during t+1; first do bit during t+2+READ_LAT; last bit during t+1+READ_LAT+DATA_W; IDLE at t+2+READ_LAT+DATA_W.
  - WRITE-then-READ: one cycle later than READ.
- stb while busy: ignored, overrun set to 1 (sticky until rst). A command must not be corrupted by it.
- stb in the same cycle the FSM returns to IDLE counts as busy, i.e. it is ignored.
- rst mid-operation: immediate return to reset state; bram_en drops asynchronously.
- Address and data are unconstrained; no wrap handling is needed.

Optional Feature:
- Macro BRAM_SERIAL_SEQ_PARITY_EN.
- With the macro:
  - bram_wpar = XOR of cmd data, registered with cmd.
  - At capture, compare bram_rpar against the XOR of bram_rdata; on mismatch set par_err (sticky until rst).
- Without the macro: bram_wpar and par_err are tied to 0, bram_rpar is unused, and no parity logic exists.

Decomposition:
- Package bram_serial_pkg:
  - state enum
  - op code constants OP_NOP, OP_WR, OP_RD, OP_WRRD
  - function frame_w(ADDR_W, DATA_W)
- One natural sub-module: bram_serial_piso (parallel-load, serial-out shift register with load/shift/zero-fill), instantiated once for do.
- The input shifter stays inline.

Test Plan (ADDR_W=10, DATA_W=8, READ_LAT=1, behavioral BRAM model):
- WRITE: shift {01, 10'h005, 8'hA5}, pulse stb -> exactly one cycle with bram_en=1, bram_we=1, addr 005, wdata A5; busy high 1 cycle; do stays 0.
- READ: preload addr 005 = 8'h3C; shift {10, 10'h005, 8'h00}, stb at t -> do = 0,0,1,1,1,1,0,0 on cycles t+3..t+10; busy falls at t+11.
- WRITE-then-READ: shift {11, 10'h3FF, 8'hFF}, stb -> write to 3FF, then read 3FF; do = eight 1s starting at t+4.
- Overrun: stb during the SHIFT of a read -> read bits unchanged, no extra en pulse, overrun=1 and stays 1 until rst.
- Reset mid-SHIFT: assert rst at bit 3 -> do, busy and bram_en go 0 immediately; a subsequent READ completes normally.
- Parity (macro on): write 8'h01 -> wpar=1; model returns DOP=0 on the read -> par_err=1 after capture. With the macro off, par_err is always 0.

Source files
------------

// File: rtl/bram_serial_seq_pkg.sv
// Shared types and helpers for the serial BRAM sequencer: FSM states, op codes, frame width.
package bram_serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE_W,
        ST_ISSUE_R,
        ST_WAIT,
        ST_SHIFT
    } state_t;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_RD   = 2'b10;
    localparam logic [1:0] OP_WRRD = 2'b11;

    // A command frame is {op[1:0], addr, data}, MSB first on the serial line.
    function automatic int frame_w(input int addr_w, input int data_w);
        return 2 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/bram_serial_seq_if.sv
// Bundle of the 3-pin serial host side and the BRAM port A side of the sequencer.
// The serial output is called sdo because "do" is a reserved word in SystemVerilog.
interface bram_serial_seq_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) ();

    logic              di;
    logic              stb;
    logic              sdo;
    logic              busy;
    logic              overrun;
    logic              bram_en;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_wdata;
    logic [DATA_W-1:0] bram_rdata;
    logic              bram_wpar;
    logic              bram_rpar;
    logic              par_err;

    modport slave (
        input  di, stb, bram_rdata, bram_rpar,
        output sdo, busy, overrun, bram_en, bram_we, bram_addr, bram_wdata,
               bram_wpar, par_err
    );

    modport master (
        output di, stb, bram_rdata, bram_rpar,
        input  sdo, busy, overrun, bram_en, bram_we, bram_addr, bram_wdata,
               bram_wpar, par_err
    );

endinterface

// File: rtl/bram_serial_seq_piso.sv
// Parallel-load, serial-out shift register: MSB out first, zero fill on shift.
module bram_serial_piso #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic              msb
);

    logic [DATA_W-1:0] q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= q << 1;
        end
    end

    assign msb = q[DATA_W-1];

endmodule

// File: rtl/bram_serial_seq.sv
// Serial-command sequencer driving one BRAM port: shift in {op, addr, data}, strobe, read back serially.
// Optional DIP/DOP parity generation and checking is enabled with `define BRAM_SERIAL_SEQ_PARITY_EN.
module bram_serial_seq
    import bram_serial_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    bram_serial_seq_if.slave     bus
);

    localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
    localparam int CNT_W   = 6;

    state_t            state;
    logic [FRAME_W-1:0] shr;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic [CNT_W-1:0]  cnt;
    logic              bram_en;
    logic              bram_we;
    logic              overrun;
    logic              capture;
    logic              piso_msb;

    logic [1:0]        op_in;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] data_in;

    assign op_in   = shr[FRAME_W-1 -: 2];
    assign addr_in = shr[DATA_W +: ADDR_W];
    assign data_in = shr[DATA_W-1:0];

    // WAIT reuses cnt as the latency countdown, SHIFT reuses it as the bit index.
    assign capture = (state == ST_WAIT) && (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            shr      <= '0;
            cmd_op   <= OP_NOP;
            cmd_addr <= '0;
            cmd_data <= '0;
            cnt      <= '0;
            bram_en  <= 1'b0;
            bram_we  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            shr     <= {shr[FRAME_W-2:0], bus.di};
            bram_en <= 1'b0;
            bram_we <= 1'b0;

            // A strobe in any non-idle cycle, including the last one, is dropped.
            if (bus.stb && (state != ST_IDLE)) begin
                overrun <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.stb) begin
                        cmd_op   <= op_in;
                        cmd_addr <= addr_in;
                        cmd_data <= data_in;
                        case (op_in)
                            OP_WR, OP_WRRD: begin
                                state   <= ST_ISSUE_W;
                                bram_en <= 1'b1;
                                bram_we <= 1'b1;
                            end
                            OP_RD: begin
                                state   <= ST_ISSUE_R;
                                bram_en <= 1'b1;
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end
                ST_ISSUE_W: begin
                    if (cmd_op == OP_WRRD) begin
                        state   <= ST_ISSUE_R;
                        bram_en <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_ISSUE_R: begin
                    cnt   <= CNT_W'(READ_LAT - 1);
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state <= ST_SHIFT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (cnt == CNT_W'(DATA_W - 1)) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    bram_serial_piso #(
        .DATA_W (DATA_W)
    ) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (capture),
        .shift (state == ST_SHIFT),
        .din   (bus.bram_rdata),
        .msb   (piso_msb)
    );

`ifdef BRAM_SERIAL_SEQ_PARITY_EN
    logic wpar;
    logic par_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wpar    <= 1'b0;
            par_err <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && bus.stb) begin
                wpar <= ^data_in;
            end
            if (capture && ((^bus.bram_rdata) != bus.bram_rpar)) begin
                par_err <= 1'b1;
            end
        end
    end

    assign bus.bram_wpar = wpar;
    assign bus.par_err   = par_err;
`else
    assign bus.bram_wpar = 1'b0;
    assign bus.par_err   = 1'b0;
`endif

    assign bus.sdo        = piso_msb & (state == ST_SHIFT);
    assign bus.busy       = (state != ST_IDLE);
    assign bus.overrun    = overrun;
    assign bus.bram_en    = bram_en;
    assign bus.bram_we    = bram_we;
    assign bus.bram_addr  = cmd_addr;
    assign bus.bram_wdata = cmd_data;

endmodule

// File: tb/tb_bram_serial_seq.sv
// Directed bench for bram_serial_seq (ADDR_W=10, DATA_W=8, READ_LAT=1) with a behavioural BRAM.
module tb_bram_serial_seq;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    bram_serial_seq_if #(.ADDR_W(10), .DATA_W(8)) bus ();

    bram_serial_seq #(
        .ADDR_W   (10),
        .DATA_W   (8),
        .READ_LAT (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural BRAM, read latency 1; preloads go through the same process.
    logic [7:0] mem     [0:1023];
    logic       mem_par [0:1023];
    int         en_count;
    logic       pre_en;
    logic [9:0] pre_addr;
    logic [7:0] pre_data;
    logic       force_dop0;

    initial en_count = 0;

    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_addr]     <= pre_data;
            mem_par[pre_addr] <= ^pre_data;
        end
        if (bus.bram_en) begin
            en_count <= en_count + 1;
            if (bus.bram_we) begin
                mem[bus.bram_addr]     <= bus.bram_wdata;
                mem_par[bus.bram_addr] <= bus.bram_wpar;
            end else begin
                bus.bram_rdata <= mem[bus.bram_addr];
                bus.bram_rpar  <= force_dop0 ? 1'b0 : mem_par[bus.bram_addr];
            end
        end
    end

    task automatic preload(input logic [9:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_addr = a;
        pre_data = d;
        pre_en   = 1'b1;
        @(negedge clk);
        pre_en   = 1'b0;
    endtask

    task automatic send_frame(input logic [1:0] op, input logic [9:0] addr, input logic [7:0] data);
        logic [19:0] f;
        f = {op, addr, data};
        for (int i = 19; i >= 0; i--) begin
            @(negedge clk);
            bus.di = f[i];
        end
    endtask

    // Strobe during cycle t; returns at the negedge of cycle t+1.
    task automatic pulse_stb;
        @(negedge clk);
        bus.stb = 1'b1;
        @(negedge clk);
        bus.stb = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; bus.di = 1'b0; bus.stb = 1'b0;
        pre_en = 1'b0; pre_addr = '0; pre_data = '0; force_dop0 = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.sdo, bus.busy, bus.overrun, bus.bram_en, bus.bram_we, bus.bram_wpar, bus.par_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000000",
                     {bus.sdo, bus.busy, bus.overrun, bus.bram_en, bus.bram_we, bus.bram_wpar, bus.par_err});
        end
        checks++;
        if (bus.bram_addr !== 10'h000) begin
            errors++; $display("FAIL reset_addr got %h want 000", bus.bram_addr);
        end
        checks++;
        if (bus.bram_wdata !== 8'h00) begin
            errors++; $display("FAIL reset_wdata got %h want 00", bus.bram_wdata);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.bram_en, bus.sdo} !== 3'b000) begin
            errors++; $display("FAIL reset_release got %b want 000", {bus.busy, bus.bram_en, bus.sdo});
        end
    endtask

    task automatic test_write;
        int e0;
        e0 = en_count;
        send_frame(2'b01, 10'h005, 8'hA5);
        pulse_stb();
        checks++;
        if ({bus.bram_en, bus.bram_we} !== 2'b11) begin
            errors++; $display("FAIL wr_en_we got %b want 11", {bus.bram_en, bus.bram_we});
        end
        checks++;
        if (bus.bram_addr !== 10'h005) begin
            errors++; $display("FAIL wr_addr got %h want 005", bus.bram_addr);
        end
        checks++;
        if (bus.bram_wdata !== 8'hA5) begin
            errors++; $display("FAIL wr_wdata got %h want a5", bus.bram_wdata);
        end
        checks++;
        if ({bus.busy, bus.sdo} !== 2'b10) begin
            errors++; $display("FAIL wr_busy_do got %b want 10", {bus.busy, bus.sdo});
        end
        @(negedge clk);
        checks++;
        if ({bus.bram_en, bus.bram_we, bus.busy, bus.sdo} !== 4'b0000) begin
            errors++; $display("FAIL wr_done got %b want 0000", {bus.bram_en, bus.bram_we, bus.busy, bus.sdo});
        end
        repeat (3) @(negedge clk);
        checks++;
        if (en_count - e0 !== 1) begin
            errors++; $display("FAIL wr_en_pulses got %0d want 1", en_count - e0);
        end
        checks++;
        if (mem[10'h005] !== 8'hA5) begin
            errors++; $display("FAIL wr_mem got %h want a5", mem[10'h005]);
        end
    endtask

    task automatic test_read;
        int         e0;
        logic [7:0] exp;
        exp = 8'h3C;
        preload(10'h005, exp);
        e0 = en_count;
        send_frame(2'b10, 10'h005, 8'h00);
        pulse_stb();
        checks++;
        if ({bus.bram_en, bus.bram_we, bus.busy} !== 3'b101 || bus.bram_addr !== 10'h005) begin
            errors++; $display("FAIL rd_issue got en/we/busy %b addr %h want 101 005",
                               {bus.bram_en, bus.bram_we, bus.busy}, bus.bram_addr);
        end
        @(negedge clk);
        checks++;
        if ({bus.sdo, bus.busy} !== 2'b01) begin
            errors++; $display("FAIL rd_wait got %b want 01", {bus.sdo, bus.busy});
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (bus.sdo !== exp[7-k] || bus.busy !== 1'b1) begin
                errors++; $display("FAIL rd_bit%0d got do %b busy %b want %b 1", k, bus.sdo, bus.busy, exp[7-k]);
            end
        end
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.sdo} !== 2'b00) begin
            errors++; $display("FAIL rd_end got %b want 00", {bus.busy, bus.sdo});
        end
        checks++;
        if (en_count - e0 !== 1) begin
            errors++; $display("FAIL rd_en_pulses got %0d want 1", en_count - e0);
        end
    endtask

    task automatic test_write_read;
        int e0;
        e0 = en_count;
        send_frame(2'b11, 10'h3FF, 8'hFF);
        pulse_stb();
        checks++;
        if ({bus.bram_en, bus.bram_we} !== 2'b11 || bus.bram_addr !== 10'h3FF || bus.bram_wdata !== 8'hFF) begin
            errors++; $display("FAIL wrrd_write got en/we %b addr %h data %h want 11 3ff ff",
                               {bus.bram_en, bus.bram_we}, bus.bram_addr, bus.bram_wdata);
        end
        @(negedge clk);
        checks++;
        if ({bus.bram_en, bus.bram_we} !== 2'b10 || bus.bram_addr !== 10'h3FF) begin
            errors++; $display("FAIL wrrd_read got en/we %b addr %h want 10 3ff",
                               {bus.bram_en, bus.bram_we}, bus.bram_addr);
        end
        @(negedge clk);
        checks++;
        if ({bus.sdo, bus.busy} !== 2'b01) begin
            errors++; $display("FAIL wrrd_wait got %b want 01", {bus.sdo, bus.busy});
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (bus.sdo !== 1'b1) begin
                errors++; $display("FAIL wrrd_bit%0d got %b want 1", k, bus.sdo);
            end
        end
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.sdo} !== 2'b00) begin
            errors++; $display("FAIL wrrd_end got %b want 00", {bus.busy, bus.sdo});
        end
        checks++;
        if (en_count - e0 !== 2 || mem[10'h3FF] !== 8'hFF) begin
            errors++; $display("FAIL wrrd_mem got pulses %0d mem %h want 2 ff", en_count - e0, mem[10'h3FF]);
        end
    endtask

    // Address 060 puts op=11 in the shifted frame at the stray strobe, so a leak would show as extra en.
    task automatic test_overrun;
        int         e0;
        logic [7:0] exp;
        exp = 8'h96;
        preload(10'h060, exp);
        checks++;
        if (bus.overrun !== 1'b0) begin
            errors++; $display("FAIL ovr_initial got %b want 0", bus.overrun);
        end
        e0 = en_count;
        send_frame(2'b10, 10'h060, 8'h00);
        @(negedge clk);
        bus.stb = 1'b1;
        bus.di  = 1'b1;
        @(negedge clk);
        bus.stb = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 3) bus.stb = 1'b0;
            checks++;
            if (bus.sdo !== exp[7-k]) begin
                errors++; $display("FAIL ovr_bit%0d got %b want %b", k, bus.sdo, exp[7-k]);
            end
            if (k == 2) bus.stb = 1'b1;
        end
        bus.di = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.overrun} !== 2'b01) begin
            errors++; $display("FAIL ovr_flag got busy/overrun %b want 01", {bus.busy, bus.overrun});
        end
        repeat (5) @(negedge clk);
        checks++;
        if (en_count - e0 !== 1 || bus.overrun !== 1'b1) begin
            errors++; $display("FAIL ovr_sticky got pulses %0d overrun %b want 1 1", en_count - e0, bus.overrun);
        end
    endtask

    task automatic test_reset_mid_op;
        logic [7:0] exp;
        exp = 8'hD3;
        preload(10'h123, exp);
        send_frame(2'b10, 10'h123, 8'h00);
        pulse_stb();
        checks++;
        if (bus.bram_en !== 1'b1) begin
            errors++; $display("FAIL rst_issue_en got %b want 1", bus.bram_en);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.bram_en, bus.busy} !== 2'b00) begin
            errors++; $display("FAIL rst_async_en got en/busy %b want 00", {bus.bram_en, bus.busy});
        end
        @(negedge clk);
        rst = 1'b0;
        send_frame(2'b10, 10'h123, 8'h00);
        pulse_stb();
        @(negedge clk);
        for (int k = 0; k < 4; k++) @(negedge clk);
        checks++;
        if (bus.sdo !== 1'b1) begin
            errors++; $display("FAIL rst_bit3 got %b want 1", bus.sdo);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.sdo, bus.busy, bus.bram_en, bus.overrun} !== 4'b0000) begin
            errors++; $display("FAIL rst_mid_shift got %b want 0000", {bus.sdo, bus.busy, bus.bram_en, bus.overrun});
        end
        @(negedge clk);
        rst = 1'b0;
        send_frame(2'b10, 10'h123, 8'h00);
        pulse_stb();
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (bus.sdo !== exp[7-k]) begin
                errors++; $display("FAIL rst_reread_bit%0d got %b want %b", k, bus.sdo, exp[7-k]);
            end
        end
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.overrun} !== 2'b00) begin
            errors++; $display("FAIL rst_reread_end got %b want 00", {bus.busy, bus.overrun});
        end
    endtask

    // Strobe held into the cycle the write returns to IDLE; addr[9]=1 makes the shifted op 11.
    task automatic test_back_to_back;
        int e0;
        e0 = en_count;
        send_frame(2'b01, 10'h200, 8'h5A);
        @(negedge clk);
        bus.stb = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL b2b_busy got %b want 1", bus.busy);
        end
        @(negedge clk);
        bus.stb = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL b2b_idle got %b want 0", bus.busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (en_count - e0 !== 1 || bus.overrun !== 1'b1 || mem[10'h200] !== 8'h5A) begin
            errors++; $display("FAIL b2b_ignored got pulses %0d overrun %b mem %h want 1 1 5a",
                               en_count - e0, bus.overrun, mem[10'h200]);
        end
    endtask

    task automatic test_parity;
        send_frame(2'b01, 10'h010, 8'h01);
        pulse_stb();
        checks++;
`ifdef BRAM_SERIAL_SEQ_PARITY_EN
        if (bus.bram_wpar !== 1'b1) begin
            errors++; $display("FAIL par_wpar got %b want 1", bus.bram_wpar);
        end
`else
        if (bus.bram_wpar !== 1'b0) begin
            errors++; $display("FAIL par_wpar got %b want 0", bus.bram_wpar);
        end
`endif
        repeat (2) @(negedge clk);
        force_dop0 = 1'b1;
        send_frame(2'b10, 10'h010, 8'h00);
        pulse_stb();
        @(negedge clk);
        checks++;
        if (bus.par_err !== 1'b0) begin
            errors++; $display("FAIL par_before_capture got %b want 0", bus.par_err);
        end
        repeat (10) @(negedge clk);
        force_dop0 = 1'b0;
        checks++;
`ifdef BRAM_SERIAL_SEQ_PARITY_EN
        if (bus.par_err !== 1'b1) begin
            errors++; $display("FAIL par_err got %b want 1", bus.par_err);
        end
`else
        if (bus.par_err !== 1'b0) begin
            errors++; $display("FAIL par_err got %b want 0", bus.par_err);
        end
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write();
        test_read();
        test_write_read();
        test_overrun();
        test_reset_mid_op();
        test_back_to_back();
        test_parity();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
